// File: rtl/bus_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter4_pkg
// Purpose  : Shared bus-controller constants: arbiter state encoding, default
//            burst hold limit, pointer reset value and round-robin helpers.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arbiter4_pkg;

  // Two-state arbiter: no owner, or exactly one owner.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Default number of transfers a locked owner may make per tenure.
  localparam int unsigned C_MAX_HOLD_DEFAULT = 4;

  // Pointer value after reset: requester 0 is scanned first.
  localparam logic [1:0] C_PTR_RESET = 2'd3;

  // First set request bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  // Returns ptr when no bit is set; callers gate on |req.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    // Walk from the lowest priority offset up so the nearest hit wins last.
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

  // Binary requester index to one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    to_onehot = 4'b0001 << idx;
  endfunction

endpackage : bus_arbiter4_pkg
`default_nettype wire

// File: rtl/bus_arbiter4_mux.sv
`default_nettype none
// ============================================================================
// Module   : Bit16_Mux4_1
// Purpose  : Four-to-one data multiplexer forming the arbiter datapath.
// Revision : 1.0 - initial release
// ============================================================================
module Bit16_Mux4_1 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  // Pure selection; no storage in the datapath.
  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule : Bit16_Mux4_1
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter4
// Purpose  : Four-requester round-robin bus arbiter with burst lock and a
//            per-tenure transfer limit. Control only; data goes through a
//            single 4:1 mux steered by the registered select.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = C_MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  arb_state_e  state_q, state_d;
  logic [3:0]  gnt_q,   gnt_d;
  logic [1:0]  sel_q,   sel_d;   // doubles as the owner index while busy
  logic [3:0]  hold_q,  hold_d;
  logic [1:0]  ptr_q,   ptr_d;

  logic        busy;
  logic        xfer;
  logic        last_xfer;
  logic        release_own;
  logic [3:0]  others;
  logic [3:0]  arb_req;
  logic [1:0]  arb_ptr;
  logic [1:0]  winner;

  assign busy      = (state_q == ST_BUSY);
  assign out_valid = busy & req[sel_q];
  assign xfer      = out_valid & ready;
  assign last_xfer = ((hold_q + 4'd1) == 4'(MAX_HOLD));

  // Release on a closing transfer, or immediately if the owner withdraws.
  assign release_own = (xfer & (~lock[sel_q] | last_xfer)) | (busy & ~req[sel_q]);

  // The departing owner is excluded; gnt_q is zero in IDLE so this is req there.
  assign others  = req & ~gnt_q;
  assign arb_req = busy ? others : req;
  assign arb_ptr = busy ? sel_q  : ptr_q;
  assign winner  = rr_pick(arb_req, arb_ptr);

  // Next-state: grant from IDLE, hand over or return to IDLE on release.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_BUSY;
          sel_d   = winner;
          gnt_d   = to_onehot(winner);
          hold_d  = 4'd0;
        end
      end
      ST_BUSY: begin
        if (release_own) begin
          ptr_d  = sel_q;
          hold_d = 4'd0;
          if (|others) begin
            sel_d = winner;
            gnt_d = to_onehot(winner);
          end else begin
            state_d = ST_IDLE;
            sel_d   = 2'd0;
            gnt_d   = 4'd0;
          end
        end else if (xfer) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'd0;
        sel_d   = 2'd0;
        hold_d  = 4'd0;
        ptr_d   = C_PTR_RESET;
      end
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      hold_q  <= 4'd0;
      ptr_q   <= C_PTR_RESET;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

  Bit16_Mux4_1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (sel_q),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .out (out)
  );

endmodule : bus_arbiter4
`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter4
// Purpose  : Self-checking bench for bus_arbiter4: vector table, directed
//            multi-cycle sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter4;

  localparam int MAXH = 4;

  logic        clk;
  logic        rst_r;
  logic [3:0]  req_r;
  logic [3:0]  lock_r;
  logic        ready_r;
  logic [15:0] d [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter4 #(
    .WIDTH    (16),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk       (clk),
    .rst       (rst_r),
    .req       (req_r),
    .lock      (lock_r),
    .in0       (d[0]),
    .in1       (d[1]),
    .in2       (d[2]),
    .in3       (d[3]),
    .ready     (ready_r),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         chk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       ready;
    logic [3:0] exp_gnt;
    logic       exp_valid;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; they are sampled at the next rising edge.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic rd);
    @(negedge clk);
    rst_r   = r;
    req_r   = rq;
    lock_r  = lk;
    ready_r = rd;
    #1;
  endtask

  function automatic int enc(input logic [3:0] g);
    enc = 0;
    for (int i = 0; i < 4; i++) if (g[i]) enc = i;
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] eg, input logic ev);
    check({tag, ".gnt"},       32'(gnt),       32'(eg));
    check({tag, ".sel"},       32'(sel),       32'(enc(eg)));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".out"},       32'(out),       32'(d[enc(eg)]));
  endtask

  // ---------------- behavioural reference ----------------
  bit m_busy;
  int m_owner, m_ptr, m_hold;

  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    bit rel;
    logic [3:0] oth;
    rel = 1'b0;
    if (!rst_r) begin
      m_busy = 1'b0; m_ptr = 3; m_hold = 0; m_owner = 0;
    end else if (!m_busy) begin
      if (req_r != 4'd0) begin
        m_owner = scan(req_r, m_ptr); m_busy = 1'b1; m_hold = 0;
      end
    end else begin
      if (!req_r[m_owner]) rel = 1'b1;
      else if (ready_r) begin
        if (!lock_r[m_owner] || (m_hold + 1 == MAXH)) rel = 1'b1;
        else m_hold = m_hold + 1;
      end
      if (rel) begin
        oth = req_r;
        oth[m_owner] = 1'b0;
        m_ptr = m_owner;
        m_hold = 0;
        if (oth != 4'd0) m_owner = scan(oth, m_ptr);
        else m_busy = 1'b0;
      end
    end
  endtask

  vec_t vt [$];

  initial begin
    rst_r = 1'b0; req_r = 4'd0; lock_r = 4'd0; ready_r = 1'b0;
    d[0] = 16'hA5A5; d[1] = 16'h1111; d[2] = 16'h2222; d[3] = 16'h3333;

    // chk, rst, req, lock, ready, exp_gnt, exp_valid
    // Single request, single transfer, back to idle.
    vt.push_back('{0, 0, 4'b0001, 4'b0000, 1, 4'b0000, 0});
    vt.push_back('{1, 0, 4'b0001, 4'b0000, 1, 4'b0000, 0});
    vt.push_back('{1, 1, 4'b0001, 4'b0000, 1, 4'b0000, 0});
    vt.push_back('{1, 1, 4'b0001, 4'b0000, 1, 4'b0001, 1});
    vt.push_back('{1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0});
    // Reset, then all four requesting: rotation with no bubble.
    vt.push_back('{1, 0, 4'b1111, 4'b0000, 1, 4'b0000, 0});
    vt.push_back('{1, 1, 4'b1111, 4'b0000, 1, 4'b0000, 0});
    vt.push_back('{1, 1, 4'b1111, 4'b0000, 1, 4'b0001, 1});
    vt.push_back('{1, 1, 4'b1111, 4'b0000, 1, 4'b0010, 1});
    vt.push_back('{1, 1, 4'b1111, 4'b0000, 1, 4'b0100, 1});
    vt.push_back('{1, 1, 4'b1111, 4'b0000, 1, 4'b1000, 1});
    vt.push_back('{1, 1, 4'b1111, 4'b0000, 1, 4'b0001, 1});
    vt.push_back('{1, 0, 4'b0000, 4'b0000, 1, 4'b0010, 0});
    // Locked burst of MAX_HOLD transfers, then hand over to requester 1.
    vt.push_back('{1, 0, 4'b0011, 4'b0001, 1, 4'b0000, 0});
    vt.push_back('{1, 1, 4'b0011, 4'b0001, 1, 4'b0000, 0});
    vt.push_back('{1, 1, 4'b0011, 4'b0001, 1, 4'b0001, 1});
    vt.push_back('{1, 1, 4'b0011, 4'b0001, 1, 4'b0001, 1});
    vt.push_back('{1, 1, 4'b0011, 4'b0001, 1, 4'b0001, 1});
    vt.push_back('{1, 1, 4'b0011, 4'b0001, 1, 4'b0001, 1});
    vt.push_back('{1, 1, 4'b0011, 4'b0001, 1, 4'b0010, 1});
    vt.push_back('{1, 1, 4'b0000, 4'b0000, 1, 4'b0001, 0});
    vt.push_back('{1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0});

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].req, vt[i].lock, vt[i].ready);
      if (vt[i].chk) check_outputs($sformatf("vec%0d", i), vt[i].exp_gnt, vt[i].exp_valid);
    end

    // Owner 2 stalled by ready=0; hold count must not move.
    drive(0, 4'b0000, 4'b0000, 0);
    drive(1, 4'b0100, 4'b0000, 0);
    check("stall.idle_gnt", 32'(gnt), 32'h0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'b0100, 4'b0000, 0);
      check_outputs($sformatf("stall%0d", c), 4'b0100, 1'b1);
      check($sformatf("stall%0d.hold", c), 32'(dut.hold_q), 32'h0);
    end
    drive(1, 4'b0100, 4'b0000, 1);
    check_outputs("stall.xfer", 4'b0100, 1'b1);
    drive(1, 4'b0000, 4'b0000, 0);
    check_outputs("stall.released", 4'b0000, 1'b0);
    check("stall.ptr", 32'(dut.ptr_q), 32'h2);

    // Owner 1 withdraws while ready=0: handover to 3, no transfer counted.
    drive(0, 4'b0000, 4'b0000, 0);
    drive(1, 4'b0010, 4'b0000, 0);
    drive(1, 4'b1001, 4'b0000, 0);
    check_outputs("drop.owner1", 4'b0010, 1'b0);
    drive(1, 4'b1001, 4'b0000, 0);
    check_outputs("drop.next", 4'b1000, 1'b1);
    check("drop.ptr", 32'(dut.ptr_q), 32'h1);
    check("drop.hold", 32'(dut.hold_q), 32'h0);

    // Reset in the middle of a locked burst by owner 2.
    drive(0, 4'b0000, 4'b0000, 0);
    drive(1, 4'b0100, 4'b0100, 1);
    drive(1, 4'b0100, 4'b0100, 1);
    check_outputs("midrst.burst", 4'b0100, 1'b1);
    drive(0, 4'b0100, 4'b0100, 1);
    check_outputs("midrst.pre", 4'b0100, 1'b1);
    drive(1, 4'b0100, 4'b0100, 1);
    check_outputs("midrst.aborted", 4'b0000, 1'b0);
    check("midrst.hold", 32'(dut.hold_q), 32'h0);
    drive(1, 4'b0100, 4'b0100, 1);
    check_outputs("midrst.regrant", 4'b0100, 1'b1);

    // Randomized traffic against the reference.
    drive(0, 4'b0000, 4'b0000, 0);
    model_edge();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] eg;
      logic       ev;
      int         es;
      @(negedge clk);
      rst_r   = ($urandom_range(0, 39) != 0);
      req_r   = 4'($urandom);
      lock_r  = 4'($urandom);
      ready_r = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
      #1;
      eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      es = m_busy ? m_owner : 0;
      ev = m_busy && req_r[m_owner];
      check($sformatf("rnd%0d.gnt", n),       32'(gnt),       32'(eg));
      check($sformatf("rnd%0d.sel", n),       32'(sel),       32'(es));
      check($sformatf("rnd%0d.out_valid", n), 32'(out_valid), 32'(ev));
      check($sformatf("rnd%0d.out", n),       32'(out),       32'(d[es]));
      model_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_arbiter4
`default_nettype wire
